// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// ----------------
// Fetch stage: owns the program counter, drives the combinational
// instruction memory address, and captures each returned word together
// with its PC into a 2-entry skid buffer that feeds decode.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect with redirect_pc[1:0] != 0 loads the PC as given
//               and raises trap. Fetch stops until the next aligned redirect
//               or reset. The buffer still drains.
//   undefined : redirect_pc[1:0] is forced to 0 on load, and trap is tied low.
//
// Ports:
//   clk            core clock, rising edge
//   rst            asynchronous, active-low reset
//   imem_addr      instruction memory byte address (= PC register)
//   imem_rdata     instruction word for imem_addr, same cycle
//   redirect_valid load redirect_pc into the PC and flush the buffer
//   redirect_pc    redirect target byte address
//   out_valid      buffer head holds an instruction
//   out_ready      decode accepts the head this cycle
//   out_instr      head instruction (0 when empty)
//   out_pc         head PC (0 when empty)
//   out_pc_plus4   head PC + 4 (0 when empty)
//   trap           misaligned-redirect trap flag
//
// Handshake: the head transfers on a rising edge where out_valid and
// out_ready are both high. out_valid depends only on registered state and
// never on out_ready. A redirect in the same cycle discards that transfer.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        trap
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_pc_q [2];
  logic [31:0] buf_pc_d [2];
  logic [31:0] buf_instr_q [2];
  logic [31:0] buf_instr_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        pop, push;
  logic [31:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q, trap_d;
  assign trap            = trap_q;
  assign redirect_target = redirect_pc;
`else
  assign trap            = 1'b0;
  // Low address bits are dropped so the PC is always word aligned.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign imem_addr    = pc_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_pc       = out_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign out_instr    = out_valid ? buf_instr_q[rd_ptr_q] : 32'h0;
  assign out_pc_plus4 = out_valid ? (buf_pc_q[rd_ptr_q] + 32'd4) : 32'h0;

  assign pop  = out_valid & out_ready;
  // A full buffer may still accept a word when the head leaves this cycle.
  assign push = ~redirect_valid & ~trap & ((count_q != 2'd2) | pop);

  always_comb begin
    pc_d        = pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_d      = trap_q;
`endif
    if (redirect_valid) begin
      // Flush wins over any concurrent pop; the buffer is emptied anyway.
      pc_d     = redirect_target;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_d   = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (push) begin
        buf_pc_d[wr_ptr_q]    = pc_q;
        buf_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = ~wr_ptr_q;
        pc_d                  = pc_q + 32'd4;  // wraps naturally at 2^32
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q           <= RESET_PC;
      buf_pc_q[0]    <= 32'h0;
      buf_pc_q[1]    <= 32'h0;
      buf_instr_q[0] <= 32'h0;
      buf_instr_q[1] <= 32'h0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= trap_d;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. Stimulus steps are aligned to 1 ns after each
// rising edge. The monitor samples on the falling edge. Instance u_dut
// (RESET_PC=0) covers ordering, backpressure, redirect, async reset and
// misaligned redirect. Instance u_wrap (RESET_PC=FFFF_FFFC) covers PC wrap.

module tb_instr_fetch_unit;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst, redirect_valid, out_ready, out_valid, trap;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus4;
  // wrap instance
  logic        rst_w, redirect_valid_w, out_ready_w, out_valid_w, trap_w;
  logic [31:0] imem_addr_w, imem_rdata_w, redirect_pc_w, out_instr_w, out_pc_w, out_pc_plus4_w;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];  // {pc, instr}

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign imem_rdata   = mem_word(imem_addr);
  assign imem_rdata_w = mem_word(imem_addr_w);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .trap(trap)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_instr(out_instr_w),
    .out_pc(out_pc_w), .out_pc_plus4(out_pc_plus4_w), .trap(trap_w)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pcs(input logic [31:0] start, input int n);
    logic [31:0] pc;
    for (int i = 0; i < n; i++) begin
      pc = start + 32'(4 * i);
      exp_q.push_back({pc, mem_word(pc)});
    end
  endtask

  // Every expected entry of a phase must have been delivered; leftovers are
  // discarded because a redirect or reset follows.
  task automatic close_phase(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge when
  // valid & ready and no redirect discards it.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h expected no transfer", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e[63:32]);
        check("sb_instr", out_instr, e[31:0]);
        check("sb_pc_plus4", out_pc_plus4, e[63:32] + 32'd4);
      end
    end
  end

  initial begin
    rst = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    rst_w = 1'b0; out_ready_w = 1'b0; redirect_valid_w = 1'b0; redirect_pc_w = 32'h0;
    repeat (3) tick();

    // reset state
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc_plus4", out_pc_plus4, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_trap", {31'h0, trap}, 32'h0);
    check("rst_wrap_imem_addr", imem_addr_w, 32'hFFFF_FFFC);

    // reset release with out_ready=1: 0, 4, 8 in order
    expect_pcs(32'h0, 3);
    rst = 1'b1; out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    close_phase("phase_release_drained");
    rst = 1'b0;
    #1;
    check("async_rst_valid_a", {31'h0, out_valid}, 32'h0);

    // backpressure: buffer fills to 2, PC holds at 0x8
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("bp_out_valid", {31'h0, out_valid}, 32'h1);
    check("bp_head_pc", out_pc, 32'h0);
    check("bp_imem_addr", imem_addr, 32'h8);
    expect_pcs(32'h0, 3);
    out_ready = 1'b1;
    repeat (3) tick();
    close_phase("phase_bp_drained");

    // redirect to 0x40 while full and out_ready=1
    check("pre_redirect_valid", {31'h0, out_valid}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    expect_pcs(32'h40, 3);
    tick();
    redirect_valid = 1'b0;
    check("redir_out_valid", {31'h0, out_valid}, 32'h0);
    check("redir_imem_addr", imem_addr, 32'h40);
    tick();
    check("redir_head_pc", out_pc, 32'h40);
    repeat (3) tick();
    out_ready = 1'b0;
    close_phase("phase_redirect_drained");

    // asynchronous reset mid-cycle with the buffer full
    tick();
    check("full_before_rst_valid", {31'h0, out_valid}, 32'h1);
    check("full_before_rst_pc", out_pc, 32'h4C);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid_b", {31'h0, out_valid}, 32'h0);
    check("async_rst_imem_addr", imem_addr, 32'h0);
    check("async_rst_out_pc", out_pc, 32'h0);

    // misaligned redirect to 0x42
    tick();
    rst = 1'b1; out_ready = 1'b1;
    expect_pcs(32'h0, 1);
    tick();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    close_phase("phase_pre_misalign_drained");
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    redirect_valid = 1'b0;
    check("mis_imem_addr", imem_addr, 32'h42);
    check("mis_trap_set", {31'h0, trap}, 32'h1);
    check("mis_out_valid", {31'h0, out_valid}, 32'h0);
    repeat (2) tick();
    check("mis_no_push_valid", {31'h0, out_valid}, 32'h0);
    check("mis_pc_held", imem_addr, 32'h42);
    check("mis_trap_held", {31'h0, trap}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    expect_pcs(32'h80, 2);
    tick();
    redirect_valid = 1'b0;
    check("mis_trap_cleared", {31'h0, trap}, 32'h0);
    check("mis_resume_addr", imem_addr, 32'h80);
    repeat (3) tick();
`else
    expect_pcs(32'h40, 2);
    tick();
    redirect_valid = 1'b0;
    check("mis_imem_addr", imem_addr, 32'h40);
    check("mis_trap_low", {31'h0, trap}, 32'h0);
    check("mis_out_valid", {31'h0, out_valid}, 32'h0);
    repeat (3) tick();
`endif
    out_ready = 1'b0;
    close_phase("phase_misalign_drained");

    // PC wrap on the second instance
    rst_w = 1'b1;
    tick();
    check("wrap_valid", {31'h0, out_valid_w}, 32'h1);
    check("wrap_first_pc", out_pc_w, 32'hFFFF_FFFC);
    check("wrap_first_plus4", out_pc_plus4_w, 32'h0);
    check("wrap_first_instr", out_instr_w, 32'hFFFF_FFFC ^ 32'h1357_9BDF);
    check("wrap_imem_addr", imem_addr_w, 32'h0);
    check("wrap_trap", {31'h0, trap_w}, 32'h0);
    out_ready_w = 1'b1;
    tick();
    check("wrap_second_pc", out_pc_w, 32'h0);
    check("wrap_second_plus4", out_pc_plus4_w, 32'h4);
    check("wrap_second_instr", out_instr_w, 32'h0050_0093);
    out_ready_w = 1'b0;

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
